// File: rtl/reset_down_sequencer.sv
// Soft-reset sequencer: drains and resets clock domains from highest to lowest
// index, holds them all in reset, then releases them from lowest to highest.
module reset_down_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned STAGE_CYCLES   = 16,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [NUM_DOMAINS-1:0] quiesce_req,
  input  logic [NUM_DOMAINS-1:0] quiesce_ack,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_DOMAINS-1:0] timeout_err
);

  localparam int unsigned      IDX_W        = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [NUM_DOMAINS-1:0] domain_reset_d;
  logic [NUM_DOMAINS-1:0] quiesce_req_d;
  logic [NUM_DOMAINS-1:0] timeout_err_d;
  logic                   done_d;
  logic                   req_ready_d;

  always_comb begin
    state_d        = state;
    cnt_d          = cnt + CNT_W'(1);
    idx_d          = idx;
    domain_reset_d = domain_reset;
    quiesce_req_d  = '0;
    timeout_err_d  = timeout_err;
    done_d         = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready) begin
          timeout_err_d = '0;
          idx_d         = IDX_LAST;
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // ack has priority over a timeout landing on the same cycle
        if (quiesce_ack[idx]) begin
          domain_reset_d[idx] = 1'b1;
          state_d             = S_ASSERT;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_err_d[idx]  = 1'b1;
          domain_reset_d[idx] = 1'b1;
          state_d             = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (cnt == STAGE_LAST) begin
          if (idx == '0) begin
            domain_reset_d = '1;
            state_d        = S_HOLD;
          end else begin
            idx_d   = idx - IDX_W'(1);
            state_d = S_DRAIN;
          end
        end
      end
      S_HOLD: begin
        domain_reset_d = '1;
        if (cnt == HOLD_LAST) begin
          idx_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // release takes effect in the first cycle of each step
        if (cnt == '0) begin
          domain_reset_d[idx] = 1'b0;
        end
        if (cnt == STAGE_LAST) begin
          if (idx == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = S_RELEASE;
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        domain_reset_d = '1;
        idx_d          = '0;
        state_d        = S_HOLD;
      end
    endcase

    if (state_d != state) begin
      cnt_d = '0;
    end

    if (state_d == S_DRAIN) begin
      quiesce_req_d[idx_d] = 1'b1;
    end

    req_ready_d = (state == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= S_HOLD;
      cnt          <= '0;
      idx          <= '0;
      domain_reset <= '1;
      quiesce_req  <= '0;
      timeout_err  <= '0;
      done         <= 1'b0;
      busy         <= 1'b1;
      req_ready    <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      domain_reset <= domain_reset_d;
      quiesce_req  <= quiesce_req_d;
      timeout_err  <= timeout_err_d;
      done         <= done_d;
      busy         <= ~req_ready_d;
      req_ready    <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_reset_down_sequencer.sv
// Directed timeline bench for reset_down_sequencer (4 domains, stage 4, hold 8, timeout 16).
module tb_reset_down_sequencer;

  localparam int unsigned ND = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready, busy, done;
  logic [ND-1:0] quiesce_req, domain_reset, timeout_err;
  logic [ND-1:0] quiesce_ack = '0;

  int checks = 0;
  int failures = 0;
  int ack_delay[ND];
  int hi_cnt[ND];

  always #5 clock = ~clock;

  reset_down_sequencer #(
    .NUM_DOMAINS   (4),
    .STAGE_CYCLES  (4),
    .HOLD_CYCLES   (8),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (8)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .domain_reset(domain_reset),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  // One checkpoint: scenario, edge number, inputs applied after the check, expected outputs.
  typedef struct {
    int         sc;
    int         at;
    logic       rv;
    logic       rstn;
    logic [3:0] dr;
    logic [3:0] qr;
    logic [3:0] te;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t vec[$];

  function automatic void add(input int sc, input int at, input logic rv, input logic rstn,
                              input logic [3:0] dr, input logic [3:0] qr, input logic [3:0] te,
                              input logic dn, input logic rdy);
    vec_t v;
    v.sc = sc; v.at = at; v.rv = rv; v.rstn = rstn;
    v.dr = dr; v.qr = qr; v.te = te; v.dn = dn; v.rdy = rdy;
    vec.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge, check the reset-ordering invariant, update the ack responder.
  task automatic tick();
    @(posedge clock);
    #1;
    checks++;
    if (!(domain_reset inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111})) begin
      failures++;
      $display("FAIL reset_order: got %b expected thermometer from MSB", domain_reset);
    end
    for (int d = 0; d < ND; d++) begin
      hi_cnt[d]      = quiesce_req[d] ? hi_cnt[d] + 1 : 0;
      quiesce_ack[d] = quiesce_req[d] && (hi_cnt[d] > ack_delay[d]);
    end
  endtask

  initial begin
    int k;
    int last;
    string tag;

    // sc0: power-up release
    add(0,  0, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0,  7, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(0,  8, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(0, 11, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(0, 12, 0, 1, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    add(0, 16, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(0, 20, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 23, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 24, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(0, 25, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    // sc1: full soft reset, immediate ack
    add(1,  0, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(1,  1, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(1,  5, 0, 1, 4'b1000, 4'b0100, 4'b0000, 0, 0);
    add(1,  6, 0, 1, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    add(1, 10, 0, 1, 4'b1100, 4'b0010, 4'b0000, 0, 0);
    add(1, 11, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(1, 16, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 28, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 29, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(1, 33, 0, 1, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    add(1, 37, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(1, 41, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 44, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 45, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(1, 46, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    // sc2: ack[2] stuck low -> timeout
    add(2,  0, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(2,  5, 0, 1, 4'b1000, 4'b0100, 4'b0000, 0, 0);
    add(2, 20, 0, 1, 4'b1000, 4'b0100, 4'b0000, 0, 0);
    add(2, 21, 0, 1, 4'b1100, 4'b0000, 4'b0100, 0, 0);
    add(2, 26, 0, 1, 4'b1110, 4'b0000, 4'b0100, 0, 0);
    add(2, 31, 0, 1, 4'b1111, 4'b0000, 4'b0100, 0, 0);
    add(2, 43, 0, 1, 4'b1111, 4'b0000, 4'b0100, 0, 0);
    add(2, 44, 0, 1, 4'b1110, 4'b0000, 4'b0100, 0, 0);
    add(2, 56, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 0);
    add(2, 60, 0, 1, 4'b0000, 4'b0000, 4'b0100, 1, 0);
    add(2, 61, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 1);
    // sc3: ack[1] 5 cycles late; accept clears previous error
    add(3,  0, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(3, 10, 0, 1, 4'b1100, 4'b0010, 4'b0000, 0, 0);
    add(3, 15, 0, 1, 4'b1100, 4'b0010, 4'b0000, 0, 0);
    add(3, 16, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(3, 21, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(3, 33, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(3, 34, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(3, 46, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(3, 49, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(3, 50, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(3, 51, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    // sc4: ack[1] on the timeout cycle wins
    add(4, 10, 0, 1, 4'b1100, 4'b0010, 4'b0000, 0, 0);
    add(4, 25, 0, 1, 4'b1100, 4'b0010, 4'b0000, 0, 0);
    add(4, 26, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(4, 31, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(4, 60, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(4, 61, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    // sc5: ack[3] stuck, resetn pulsed during drain of domain 2, then power-up release
    add(5,  0, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(5, 15, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(5, 16, 0, 1, 4'b1000, 4'b0000, 4'b1000, 0, 0);
    add(5, 20, 0, 0, 4'b1000, 4'b0100, 4'b1000, 0, 0);
    add(5, 21, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(5, 29, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(5, 30, 0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0);
    add(5, 34, 0, 1, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    add(5, 38, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(5, 42, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(5, 45, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(5, 46, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(5, 47, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    // sc6: req_valid held high; one sequence per IDLE visit
    add(6,  0, 1, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(6,  1, 1, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(6, 20, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(6, 44, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(6, 45, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(6, 46, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);
    add(6, 47, 0, 1, 4'b0000, 4'b1000, 4'b0000, 0, 0);
    add(6, 48, 0, 1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(6, 92, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add(6, 93, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1);

    for (int d = 0; d < ND; d++) begin
      ack_delay[d] = 0;
      hi_cnt[d]    = 0;
    end

    resetn = 1'b0;
    repeat (3) tick();
    chk("reset domain_reset", 32'(domain_reset), 32'hF);
    chk("reset quiesce_req",  32'(quiesce_req),  32'h0);
    chk("reset timeout_err",  32'(timeout_err),  32'h0);
    chk("reset done",         32'(done),         32'h0);
    chk("reset busy",         32'(busy),         32'h1);
    chk("reset req_ready",    32'(req_ready),    32'h0);
    resetn = 1'b1;

    k = 0;
    for (int s = 0; s < 7; s++) begin
      for (int d = 0; d < ND; d++) ack_delay[d] = 0;
      case (s)
        2: ack_delay[2] = 1000;
        3: ack_delay[1] = 5;
        4: ack_delay[1] = 15;
        5: ack_delay[3] = 1000;
        default: ;
      endcase
      req_valid = (s != 0);
      last = 0;
      foreach (vec[i]) if (vec[i].sc == s && vec[i].at > last) last = vec[i].at;
      for (int e = 0; e <= last; e++) begin
        tick();
        if (k < vec.size() && vec[k].sc == s && vec[k].at == e) begin
          tag = $sformatf("sc%0d@e%0d", s, e);
          chk({tag, " domain_reset"}, 32'(domain_reset), 32'(vec[k].dr));
          chk({tag, " quiesce_req"},  32'(quiesce_req),  32'(vec[k].qr));
          chk({tag, " timeout_err"},  32'(timeout_err),  32'(vec[k].te));
          chk({tag, " done"},         32'(done),         32'(vec[k].dn));
          chk({tag, " req_ready"},    32'(req_ready),    32'(vec[k].rdy));
          chk({tag, " busy"},         32'(busy),         32'(!vec[k].rdy));
          req_valid = vec[k].rv;
          resetn    = vec[k].rstn;
          k++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
